// File: rtl/wtm_mac_acc.sv
// Sums LEN consecutive 10-bit Wallace-tree products into a saturating ACC_W-bit accumulator.
// Result registered on the LEN-th accept; in_ready drops while a result waits for out_ready.
module wtm_mac_acc #(
    parameter int ACC_W = 16,
    parameter int LEN   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [9:0]                 product,
    input  logic                       prod_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           acc_out,
    output logic [$clog2(LEN+1)-1:0]   count,
    output logic                       overflow,
    output logic                       err
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [ACC_W:0]   sum;

    assign in_ready  = (state != DONE) & ~clear & ~reset;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

    // One extra bit catches the carry out of the accumulator for saturation.
    assign sum = {1'b0, acc_out} + (ACC_W + 1)'(product);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (LEN == 1) ? DONE : ACCUM;
            end
            ACCUM: begin
                if (accept && (count == LAST_CNT)) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset || clear) state_nxt = IDLE;
    end

    always_ff @(posedge clock) begin
        state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            acc_out  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_out <= ACC_W'(product);
                        count   <= CW'(1);
                        err     <= prod_cout;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (sum[ACC_W]) begin
                            acc_out  <= '1;
                            overflow <= 1'b1;
                        end else begin
                            acc_out <= sum[ACC_W-1:0];
                        end
                        count <= count + CW'(1);
                        err   <= err | prod_cout;
                    end
                end
                DONE: begin
                    // acc_out stays visible through IDLE until the next result starts.
                    if (out_ready) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wtm_mac_acc.sv
// Bench for wtm_mac_acc: a 16-bit and an 11-bit instance share all inputs and are
// compared against an integer dot-product model with saturation.
module tb_wtm_mac_acc;

    localparam int LEN = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  product = '0;
    logic        prod_cout = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, overflow, err;
    logic [15:0] acc_out;
    logic [2:0]  count;
    logic        in_ready_s, out_valid_s, overflow_s, err_s;
    logic [10:0] acc_out_s;
    logic [2:0]  count_s;

    int checks = 0;
    int failures = 0;

    // Model: index 0 is the 16-bit instance, index 1 the 11-bit instance.
    bit m_done = 1'b0;
    int m_cnt = 0;
    int m_acc [2] = '{0, 0};
    bit m_ovf [2] = '{1'b0, 1'b0};
    bit m_err = 1'b0;
    int m_max [2] = '{65535, 2047};
    bit rdy_obs, rdy_s_obs, rdy_exp;

    wtm_mac_acc #(.ACC_W(16), .LEN(LEN)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .prod_cout(prod_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .count(count), .overflow(overflow), .err(err)
    );

    wtm_mac_acc #(.ACC_W(11), .LEN(LEN)) dut_s (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .product(product), .prod_cout(prod_cout),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .acc_out(acc_out_s), .count(count_s), .overflow(overflow_s), .err(err_s)
    );

    always #5 clock = ~clock;

    // Drives one cycle of inputs, samples in_ready mid-cycle, advances the model at the edge.
    task automatic step(input bit iv, input int p, input bit pc, input bit ordy,
                        input bit clr, input bit rst);
        in_valid  = iv;
        product   = 10'(p);
        prod_cout = pc;
        out_ready = ordy;
        clear     = clr;
        reset     = rst;
        #3;
        rdy_obs   = in_ready;
        rdy_s_obs = in_ready_s;
        rdy_exp   = !m_done && !clr && !rst;
        @(posedge clock);
        if (rst || clr) begin
            m_done = 1'b0; m_cnt = 0; m_err = 1'b0;
            for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        end else if (m_done) begin
            if (ordy) begin
                m_done = 1'b0; m_cnt = 0; m_err = 1'b0;
                for (int k = 0; k < 2; k++) m_ovf[k] = 1'b0;
            end
        end else if (iv) begin
            for (int k = 0; k < 2; k++) begin
                if (m_cnt == 0) m_acc[k] = p;
                else if (m_acc[k] + p > m_max[k]) begin m_acc[k] = m_max[k]; m_ovf[k] = 1'b1; end
                else m_acc[k] = m_acc[k] + p;
            end
            if (pc) m_err = 1'b1;
            m_cnt++;
            if (m_cnt == LEN) m_done = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 1);
            checks++; if (rdy_obs !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", rdy_obs); end
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (acc_out !== 16'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", acc_out); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({overflow, err, overflow_s, err_s} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {overflow, err, overflow_s, err_s}); end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b exp=1", rdy_obs); end
    endtask

    task automatic test_basic();
        int vals [4] = '{961, 3, 0, 36};
        for (int i = 0; i < 4; i++) begin
            step(1, vals[i], 0, 1, 0, 0);
            checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL basic_in_ready[%0d] got=%0b exp=1", i, rdy_obs); end
            if (i < 3) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid[%0d] got=%0b exp=0", i, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", out_valid); end
        checks++; if (acc_out !== 16'd1000) begin failures++; $display("FAIL basic_acc got=%0d exp=1000", acc_out); end
        checks++; if (acc_out_s !== 11'd1000) begin failures++; $display("FAIL basic_acc_s got=%0d exp=1000", acc_out_s); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL basic_count got=%0d exp=4", count); end
        checks++; if ({overflow, err} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {overflow, err}); end
        step(0, 0, 0, 1, 0, 0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%0b exp=0", out_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL basic_count_cleared got=%0d exp=0", count); end
        checks++; if (acc_out !== 16'd1000) begin failures++; $display("FAIL basic_acc_held_idle got=%0d exp=1000", acc_out); end
    endtask

    task automatic test_gaps_backpressure();
        int vals [4] = '{961, 3, 0, 36};
        for (int i = 0; i < 4; i++) begin
            step(1, vals[i], 0, 0, 0, 0);
            checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL gap_in_ready[%0d] got=%0b exp=1", i, rdy_obs); end
            if (i < 3) begin
                step(0, 0, 0, 0, 0, 0);
                step(0, 0, 0, 0, 0, 0);
            end
        end
        for (int j = 0; j < 5; j++) begin
            step(1, 7, 0, 0, 0, 0);
            checks++; if (rdy_obs !== 1'b0) begin failures++; $display("FAIL done_in_ready[%0d] got=%0b exp=0", j, rdy_obs); end
            checks++; if (out_valid !== 1'b1 || acc_out !== 16'd1000) begin failures++; $display("FAIL done_hold[%0d] got=%0b/%0d exp=1/1000", j, out_valid, acc_out); end
        end
        step(1, 7, 0, 1, 0, 0);
        checks++; if (rdy_obs !== 1'b0) begin failures++; $display("FAIL done_release_in_ready got=%0b exp=0", rdy_obs); end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL done_release got=%0b/%0d exp=0/0", out_valid, count); end
        step(1, 7, 0, 0, 0, 0);
        checks++; if (count !== 3'd1 || acc_out !== 16'd7) begin failures++; $display("FAIL post_done_accept got=%0d/%0d exp=1/7", count, acc_out); end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || acc_out !== 16'd7) begin failures++; $display("FAIL post_done_result got=%0b/%0d exp=1/7", out_valid, acc_out); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_saturate();
        int vals [4] = '{961, 961, 961, 5};
        for (int i = 0; i < 4; i++) begin
            step(1, vals[i], 0, 0, 0, 0);
            if (i == 1) begin
                checks++; if (acc_out_s !== 11'd1922 || overflow_s !== 1'b0) begin failures++; $display("FAIL sat_pre got=%0d/%0b exp=1922/0", acc_out_s, overflow_s); end
            end
            if (i >= 2) begin
                checks++; if (acc_out_s !== 11'd2047) begin failures++; $display("FAIL sat_acc[%0d] got=%0d exp=2047", i, acc_out_s); end
            end
        end
        checks++; if (out_valid_s !== 1'b1 || overflow_s !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%0b/%0b exp=1/1", out_valid_s, overflow_s); end
        checks++; if (acc_out !== 16'd2888 || overflow !== 1'b0) begin failures++; $display("FAIL sat_wide got=%0d/%0b exp=2888/0", acc_out, overflow); end
        step(0, 0, 0, 1, 0, 0);
        checks++; if (overflow_s !== 1'b0 || out_valid_s !== 1'b0) begin failures++; $display("FAIL sat_cleared got=%0b/%0b exp=0/0", overflow_s, out_valid_s); end
    endtask

    task automatic test_err();
        int vals [4] = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) step(1, vals[i], (i == 1), 0, 0, 0);
        checks++; if (acc_out !== 16'd100 || err !== 1'b1 || err_s !== 1'b1) begin failures++; $display("FAIL err_result got=%0d/%0b/%0b exp=100/1/1", acc_out, err, err_s); end
        step(0, 0, 0, 1, 0, 0);
        step(1, 5, 0, 0, 0, 0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_next_window_first got=%0b exp=0", err); end
        for (int i = 0; i < 3; i++) step(1, 5, 0, 0, 0, 0);
        checks++; if (err !== 1'b0 || acc_out !== 16'd20 || out_valid !== 1'b1) begin failures++; $display("FAIL err_next_window got=%0b/%0d/%0b exp=0/20/1", err, acc_out, out_valid); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_clear();
        step(1, 20, 0, 0, 0, 0);
        step(1, 30, 0, 0, 0, 0);
        checks++; if (acc_out !== 16'd50 || count !== 3'd2) begin failures++; $display("FAIL clear_pre got=%0d/%0d exp=50/2", acc_out, count); end
        step(1, 99, 0, 0, 1, 0);
        checks++; if (rdy_obs !== 1'b0) begin failures++; $display("FAIL clear_in_ready got=%0b exp=0", rdy_obs); end
        checks++; if (acc_out !== 16'd0 || count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL clear_state got=%0d/%0d/%0b exp=0/0/0", acc_out, count, out_valid); end
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0, 0);
        checks++; if (acc_out !== 16'd10 || out_valid !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL clear_restart got=%0d/%0b/%0d exp=10/1/4", acc_out, out_valid, count); end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_in_done();
        for (int i = 0; i < 4; i++) step(1, $urandom_range(1, 1023), 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_done_pre got=%0b exp=1", out_valid); end
        step(0, 0, 0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0 || acc_out !== 16'd0 || count !== 3'd0) begin failures++; $display("FAIL rst_done_state got=%0b/%0d/%0d exp=0/0/0", out_valid, acc_out, count); end
        checks++; if ({overflow, err, overflow_s, err_s} !== 4'b0) begin failures++; $display("FAIL rst_done_flags got=%b exp=0000", {overflow, err, overflow_s, err_s}); end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (rdy_obs !== 1'b1) begin failures++; $display("FAIL rst_done_in_ready got=%0b exp=1", rdy_obs); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1023), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
            checks++; if (rdy_obs !== rdy_exp || rdy_s_obs !== rdy_exp) begin failures++; $display("FAIL rnd_in_ready[%0d] got=%0b/%0b exp=%0b", n, rdy_obs, rdy_s_obs, rdy_exp); end
            checks++; if (out_valid !== m_done || out_valid_s !== m_done) begin failures++; $display("FAIL rnd_out_valid[%0d] got=%0b/%0b exp=%0b", n, out_valid, out_valid_s, m_done); end
            checks++; if (acc_out !== 16'(m_acc[0])) begin failures++; $display("FAIL rnd_acc[%0d] got=%0d exp=%0d", n, acc_out, m_acc[0]); end
            checks++; if (acc_out_s !== 11'(m_acc[1])) begin failures++; $display("FAIL rnd_acc_s[%0d] got=%0d exp=%0d", n, acc_out_s, m_acc[1]); end
            checks++; if (count !== 3'(m_cnt) || count_s !== 3'(m_cnt)) begin failures++; $display("FAIL rnd_count[%0d] got=%0d/%0d exp=%0d", n, count, count_s, m_cnt); end
            checks++; if (overflow !== m_ovf[0] || overflow_s !== m_ovf[1]) begin failures++; $display("FAIL rnd_overflow[%0d] got=%0b/%0b exp=%0b/%0b", n, overflow, overflow_s, m_ovf[0], m_ovf[1]); end
            checks++; if (err !== m_err || err_s !== m_err) begin failures++; $display("FAIL rnd_err[%0d] got=%0b/%0b exp=%0b", n, err, err_s, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_saturate();
        test_err();
        test_clear();
        test_reset_in_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wtm_mac_acc.md
# wtm_mac_acc

Multiply-accumulate back end for the 5x5 Wallace-tree multiplier. It takes one 10-bit product per cycle over a valid/ready handshake and sums LEN consecutive products into a saturating ACC_W-bit accumulator. It then holds the dot-product result until it is accepted downstream. It sits directly after the multiplier's product/carry outputs and is the first registered stage of the multiply datapath.

## Interface
Parameters:
- ACC_W, default 16: accumulator and result width. Must be at least 10.
- LEN, default 4: number of products summed per result. Must be at least 1.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- clear, input, 1: synchronous abort. Same effect as reset.
- in_valid, input, 1: a product is present on product/prod_cout.
- in_ready, output, 1: block can accept a product this cycle.
- product, input, 10: unsigned product from the multiplier.
- prod_cout, input, 1: multiplier carry-out. It must be 0 for legal operands.
- out_valid, output, 1: result is available.
- out_ready, input, 1: downstream accepts the result.
- acc_out, output, ACC_W: accumulated result, registered.
- count, output, $clog2(LEN+1): products accumulated so far.
- overflow, output, 1: sticky for the current result. Set when saturation occurred.
- err, output, 1: sticky for the current result. Set when any accepted product had prod_cout=1.

## Operation
- A product is accepted on a cycle where in_valid & in_ready.
- in_ready is combinational: (state != DONE) & ~clear & ~reset.
- The state machine has three states: IDLE, ACCUM, DONE.
- IDLE:
  - On accept: acc_out <= zero-extended product, count <= 1.
  - Next state is ACCUM, or DONE if LEN == 1.
- ACCUM:
  - On accept: acc_out <= sat(acc_out + product), count <= count + 1.
  - When count + 1 == LEN, next state is DONE.
  - With no accept, all registers hold.
- DONE:
  - out_valid = 1, in_ready = 0; acc_out, count, overflow and err hold.
  - On out_ready: next state is IDLE, count <= 0, overflow <= 0, err <= 0.
  - acc_out keeps its last value in IDLE until the next accept overwrites it.
- Arithmetic:
  - The sum is computed ACC_W+1 bits wide.
  - If bit ACC_W is set, acc_out <= all ones and overflow <= 1.
  - Once saturated, further adds keep acc_out at all ones.
- err:
  - On accept with prod_cout = 1, err <= 1.
  - The product bits are still added as given; prod_cout is never added.
- reset or clear:
  - Next state IDLE; acc_out, count, overflow and err <= 0.
  - Applies from any state, including mid-accumulation and while out_valid is high.
  - A product offered on the same cycle is not accepted.
  - clear and reset have equal priority, and both override every other input.
- out_valid is asserted only in DONE and is a function of state alone.

## Timing
- Reset values: state IDLE, acc_out 0, count 0, overflow 0, err 0, out_valid 0. in_ready is 0 while reset is high, and 1 on the first cycle after reset.
- Latency: out_valid rises on the clock edge that accepts the LEN-th product, i.e. visible the following cycle.
- Throughput: one product per cycle while not in DONE.
- Each result occupies at least LEN+1 cycles: LEN accepts plus at least one DONE cycle.
- An out_ready pulse in DONE returns to IDLE on that edge; a new product can be accepted the next cycle.
- out_ready outside DONE has no effect.
- in_valid may drop between products; gaps only stretch ACCUM.

## Test plan
1. Reset, then feed LEN=4 products 31*31=961, 3, 0, 36 back-to-back with out_ready=1 held. Expected:
   - in_ready=1 throughout.
   - out_valid for exactly 1 cycle, starting the cycle after the 4th accept.
   - acc_out=1000, count=4, overflow=0, err=0.
   - count=0 the following cycle.
2. Same stream with in_valid gaps of 2 cycles and out_ready=0 for 5 cycles in DONE. Expected:
   - acc_out=1000 held for all 5 cycles.
   - in_ready=0 during DONE.
   - A product offered during DONE is not consumed until after out_ready.
3. ACC_W=11, LEN=4, products 961, 961, 961, 5. Expected:
   - acc_out=2047 after the 3rd accept and remains 2047.
   - overflow=1 at out_valid.
   - overflow=0 after acceptance.
4. prod_cout=1 on the 2nd of 4 products valued 10, 20, 30, 40. Expected:
   - acc_out=100, err=1 at out_valid.
   - err cleared in the next result window.
5. Assert clear after 2 accepts (sum 50) while in_valid=1. Expected:
   - That product is not accepted.
   - Next cycle: state IDLE, acc_out=0, count=0.
   - A following 4-product stream 1, 2, 3, 4 yields acc_out=10.
6. Assert reset during DONE with out_ready=0. Expected:
   - out_valid=0 next cycle.
   - All outputs at their reset values.
   - in_ready=1 once reset deasserts.
